bundle_serializer: RTL and testbench

- Transmit side of the four-field test bundle: aUInt4 (4b), aSInt5 (5b), aBundle_aBool (1b), aBottomBool (1b).
- Accepts one bundle per ready/valid handshake and packs it into an 11-bit word.
- Shifts that word out as BEAT_W-bit beats on a ready/valid link, LSB beat first, with a last-beat flag.
- Feeds the matching deserializer, which rebuilds the parallel bundle for pass-through modules.

---
 rtl/bundle_link_pkg.sv | 46 ++++
 rtl/bundle_beat_shifter.sv | 46 ++++
 rtl/bundle_serializer.sv | 130 +++++++++++++
 tb/tb_bundle_serializer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bundle_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bundle_link_pkg
// Description : Shared definitions for the four-field test bundle link:
//               packed layout, field offsets, beat-count helper, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package bundle_link_pkg;

    localparam int BUNDLE_W  = 11;
    localparam int UINT4_LSB = 0;
    localparam int SINT5_LSB = 4;
    localparam int ABOOL_BIT = 9;
    localparam int BBOOL_BIT = 10;

    // Field order is MSB first so the struct bits line up with the packed word.
    typedef struct packed {
        logic       aBottomBool;
        logic       aBundle_aBool;
        logic [4:0] aSInt5;
        logic [3:0] aUInt4;
    } bundle_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } serState_t;

    // Beats needed to carry one bundle at the given beat width.
    function automatic int nbeats(input int beatW);
        return (BUNDLE_W + beatW - 1) / beatW;
    endfunction

    // Place each field at its fixed offset in the packed word.
    function automatic logic [BUNDLE_W-1:0] packBundle(input bundle_t b);
        logic [BUNDLE_W-1:0] p;
        p                  = '0;
        p[UINT4_LSB +: 4]  = b.aUInt4;
        p[SINT5_LSB +: 5]  = b.aSInt5;
        p[ABOOL_BIT]       = b.aBundle_aBool;
        p[BBOOL_BIT]       = b.aBottomBool;
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bundle_beat_shifter.sv
`default_nettype none
// ============================================================================
// Module      : bundle_beat_shifter
// Description : Parallel-load right-shift register with beat index. Presents
//               the low BEAT_W bits as the current beat and flags the last one.
// Revision    : 1.0 - initial release
// ============================================================================
module bundle_beat_shifter #(
    parameter int BEAT_W = 4,
    parameter int NBEATS = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load,
    input  logic [NBEATS*BEAT_W-1:0] loadData,
    input  logic                     advance,
    output logic [BEAT_W-1:0]        beatBits,
    output logic                     atLast
);

    localparam int FRAME_W = NBEATS * BEAT_W;
    localparam int IDX_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    logic [FRAME_W-1:0] r_shiftReg;
    logic [IDX_W-1:0]   r_idx;

    // Load wins over advance so a new frame can start as the old one ends.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shiftReg <= '0;
            r_idx      <= '0;
        end else if (load) begin
            r_shiftReg <= loadData;
            r_idx      <= '0;
        end else if (advance && (r_idx != LAST_IDX)) begin
            r_shiftReg <= r_shiftReg >> BEAT_W;
            r_idx      <= r_idx + IDX_W'(1);
        end
    end

    assign beatBits = r_shiftReg[BEAT_W-1:0];
    assign atLast   = (r_idx == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/bundle_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bundle_serializer
// Description : Accepts a four-field bundle per handshake, packs it into an
//               11-bit word and sends it LSB-first as BEAT_W-bit beats with a
//               last flag. Back-to-back frames run with no idle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bundle_serializer #(
    parameter int BEAT_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [3:0]        io_in_aUInt4,
    input  logic [4:0]        io_in_aSInt5,
    input  logic              io_in_aBundle_aBool,
    input  logic              io_in_aBottomBool,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [BEAT_W-1:0] io_out_bits,
    output logic              io_out_last,
    output logic [CNT_W-1:0]  io_frames_sent
);

    import bundle_link_pkg::*;

    localparam int NBEATS  = nbeats(BEAT_W);
    localparam int FRAME_W = NBEATS * BEAT_W;

    serState_t           r_state;
    serState_t           w_stateNext;
    logic                w_inReady;
    logic                w_inFire;
    logic                w_outValid;
    logic                w_outFire;
    logic                w_last;
    logic                w_isLastIdx;
    bundle_t             w_bundle;
    logic [BUNDLE_W-1:0] w_packed;
    logic [FRAME_W-1:0]  w_frame;
    logic [BEAT_W-1:0]   w_beatBits;
    logic [CNT_W-1:0]    r_framesSent;

    assign w_bundle = '{aBottomBool:   io_in_aBottomBool,
                        aBundle_aBool: io_in_aBundle_aBool,
                        aSInt5:        io_in_aSInt5,
                        aUInt4:        io_in_aUInt4};
    assign w_packed = packBundle(w_bundle);

    // Pad bits above the bundle are forced to zero when the frame is wider.
    generate
        if (FRAME_W > BUNDLE_W) begin : g_pad
            assign w_frame = {{(FRAME_W - BUNDLE_W){1'b0}}, w_packed};
        end else begin : g_noPad
            assign w_frame = w_packed;
        end
    endgenerate

    bundle_beat_shifter #(
        .BEAT_W (BEAT_W),
        .NBEATS (NBEATS)
    ) u_shifter (
        .clock    (clock),
        .reset    (reset),
        .load     (w_inFire),
        .loadData (w_frame),
        .advance  (w_outFire),
        .beatBits (w_beatBits),
        .atLast   (w_isLastIdx)
    );

    assign w_inFire  = io_in_valid && w_inReady;
    assign w_outFire = w_outValid && io_out_ready;

    // State register; an asynchronous reset drops any partial frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state and handshake; ready reaches back to io_out_ready only on the last beat.
    always_comb begin
        w_stateNext = r_state;
        w_outValid  = 1'b0;
        w_last      = 1'b0;
        w_inReady   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_inReady = 1'b1;
                if (io_in_valid) begin
                    w_stateNext = ST_SEND;
                end
            end
            ST_SEND: begin
                w_outValid = 1'b1;
                w_last     = w_isLastIdx;
                w_inReady  = w_isLastIdx && io_out_ready;
                if (w_isLastIdx && io_out_ready) begin
                    w_stateNext = io_in_valid ? ST_SEND : ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Completed-frame counter, wrapping at 2^CNT_W.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_framesSent <= '0;
        end else if (w_outFire && w_last) begin
            r_framesSent <= r_framesSent + CNT_W'(1);
        end
    end

    assign io_in_ready    = w_inReady;
    assign io_out_valid   = w_outValid;
    assign io_out_last    = w_last;
    assign io_out_bits    = w_outValid ? w_beatBits : '0;
    assign io_frames_sent = r_framesSent;

endmodule
`default_nettype wire

// File: tb/tb_bundle_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bundle_serializer
// Description : Self-checking bench for bundle_serializer. A beat-queue model
//               predicts valid/last/ready/bits/frame count each cycle; three
//               extra instances cover the beat-width sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bundle_serializer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       io_in_valid = 1'b0;
    logic       io_in_ready;
    logic [3:0] io_in_aUInt4 = '0;
    logic [4:0] io_in_aSInt5 = '0;
    logic       io_in_aBundle_aBool = 1'b0;
    logic       io_in_aBottomBool = 1'b0;
    logic       io_out_valid;
    logic       io_out_ready = 1'b1;
    logic [3:0] io_out_bits;
    logic       io_out_last;
    logic [7:0] io_frames_sent;

    // Sweep instances share the field inputs and a common valid.
    logic        swValid = 1'b0;
    logic        swInReady[3];
    logic        swOutValid[3];
    logic        swLast[3];
    logic [7:0]  swFrames[3];
    logic [0:0]  swBits1;
    logic [2:0]  swBits3;
    logic [10:0] swBits11;
    logic [10:0] swBits[3];

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [3:0] q[$];
    logic [7:0] mFrames = '0;
    logic       lastInFire = 1'b0;

    always #5 clock = ~clock;

    bundle_serializer #(.BEAT_W(4), .CNT_W(8)) u_dut (
        .clock(clock), .reset(reset),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
        .io_in_aUInt4(io_in_aUInt4), .io_in_aSInt5(io_in_aSInt5),
        .io_in_aBundle_aBool(io_in_aBundle_aBool), .io_in_aBottomBool(io_in_aBottomBool),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .io_out_bits(io_out_bits), .io_out_last(io_out_last),
        .io_frames_sent(io_frames_sent)
    );

    bundle_serializer #(.BEAT_W(1), .CNT_W(8)) u_sw1 (
        .clock(clock), .reset(reset),
        .io_in_valid(swValid), .io_in_ready(swInReady[0]),
        .io_in_aUInt4(io_in_aUInt4), .io_in_aSInt5(io_in_aSInt5),
        .io_in_aBundle_aBool(io_in_aBundle_aBool), .io_in_aBottomBool(io_in_aBottomBool),
        .io_out_valid(swOutValid[0]), .io_out_ready(1'b1),
        .io_out_bits(swBits1), .io_out_last(swLast[0]),
        .io_frames_sent(swFrames[0])
    );

    bundle_serializer #(.BEAT_W(3), .CNT_W(8)) u_sw3 (
        .clock(clock), .reset(reset),
        .io_in_valid(swValid), .io_in_ready(swInReady[1]),
        .io_in_aUInt4(io_in_aUInt4), .io_in_aSInt5(io_in_aSInt5),
        .io_in_aBundle_aBool(io_in_aBundle_aBool), .io_in_aBottomBool(io_in_aBottomBool),
        .io_out_valid(swOutValid[1]), .io_out_ready(1'b1),
        .io_out_bits(swBits3), .io_out_last(swLast[1]),
        .io_frames_sent(swFrames[1])
    );

    bundle_serializer #(.BEAT_W(11), .CNT_W(8)) u_sw11 (
        .clock(clock), .reset(reset),
        .io_in_valid(swValid), .io_in_ready(swInReady[2]),
        .io_in_aUInt4(io_in_aUInt4), .io_in_aSInt5(io_in_aSInt5),
        .io_in_aBundle_aBool(io_in_aBundle_aBool), .io_in_aBottomBool(io_in_aBottomBool),
        .io_out_valid(swOutValid[2]), .io_out_ready(1'b1),
        .io_out_bits(swBits11), .io_out_last(swLast[2]),
        .io_frames_sent(swFrames[2])
    );

    assign swBits[0] = 11'(swBits1);
    assign swBits[1] = 11'(swBits3);
    assign swBits[2] = swBits11;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Packed word straight from the field layout, using plain arithmetic.
    function automatic int modelPack(input logic [3:0] u, input logic [4:0] s,
                                     input logic a, input logic b);
        return int'(u) + int'(s) * 16 + int'(a) * 512 + int'(b) * 1024;
    endfunction

    // One clock cycle: drive inputs, compare against the beat queue, advance the model.
    task automatic tick(input logic v, input logic [3:0] u, input logic [4:0] s,
                        input logic a, input logic b, input logic rdy);
        int   r;
        int   p;
        logic expReady;
        @(negedge clock);
        io_in_valid         = v;
        io_in_aUInt4        = u;
        io_in_aSInt5        = s;
        io_in_aBundle_aBool = a;
        io_in_aBottomBool   = b;
        io_out_ready        = rdy;
        #1;
        r        = q.size();
        expReady = (r == 0) || ((r == 1) && rdy);
        check("out_valid",   io_out_valid,   r > 0);
        check("out_last",    io_out_last,    r == 1);
        check("in_ready",    io_in_ready,    expReady);
        check("frames_sent", io_frames_sent, mFrames);
        if (r > 0) check("out_bits", io_out_bits, q[0]);
        lastInFire = v && expReady;
        if ((r > 0) && rdy) begin
            if (r == 1) mFrames = mFrames + 8'd1;
            void'(q.pop_front());
        end
        if (lastInFire) begin
            p = modelPack(u, s, a, b);
            for (int k = 0; k < 3; k++) q.push_back(4'((p >> (4 * k)) & 15));
        end
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        mFrames = '0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Offer n random bundles with valid held high, then drain and idle one cycle.
    task automatic runFrames(input int n);
        int         acc = 0;
        int         cyc = 0;
        logic [3:0] u = 4'($urandom);
        logic [4:0] s = 5'($urandom);
        logic       a = 1'($urandom);
        logic       b = 1'($urandom);
        while ((acc < n) && (cyc < n * 8 + 20)) begin
            tick(1'b1, u, s, a, b, 1'b1);
            cyc++;
            if (lastInFire) begin
                acc++;
                u = 4'($urandom); s = 5'($urandom); a = 1'($urandom); b = 1'($urandom);
            end
        end
        check("frames_accepted", acc, n);
        for (int i = 0; (i < 8) && (q.size() > 0); i++) tick(1'b0, u, s, a, b, 1'b1);
        tick(1'b0, u, s, a, b, 1'b1);
    endtask

    initial begin
        int          bw[3] = '{1, 3, 11};
        int          nb[3] = '{11, 4, 1};
        int          cnt[3];
        logic [63:0] acc[3];
        int          p;

        // Reset held across clock edges, then released.
        repeat (2) @(negedge clock);
        reset = 1'b1;
        tick(1'b0, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1);
        check("reset_bits", io_out_bits, 4'h0);

        // Single frame: 0xA, -3, 1, 0 -> beats 0xA, 0xD, 0x3.
        tick(1'b1, 4'hA, 5'h1D, 1'b1, 1'b0, 1'b1);
        repeat (3) tick(1'b0, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1);
        check("frames_single", io_frames_sent, 8'd1);

        // Backpressure on beat 1 for three cycles.
        tick(1'b1, 4'hA, 5'h1D, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1);
        repeat (3) tick(1'b0, 4'h0, 5'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) tick(1'b0, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1);
        check("frames_stall", io_frames_sent, 8'd2);

        // Back-to-back frames with no bubble.
        runFrames(4);
        check("frames_b2b", io_frames_sent, 8'd6);

        // Asynchronous reset after beat 0 of a frame.
        tick(1'b1, 4'h5, 5'h0A, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("rst_out_valid", io_out_valid, 1'b0);
        check("rst_out_last",  io_out_last,  1'b0);
        q.delete();
        mFrames = '0;
        @(negedge clock);
        reset = 1'b1;
        tick(1'b0, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1);
        check("rst_bits", io_out_bits, 4'h0);
        tick(1'b1, 4'h3, 5'h15, 1'b1, 1'b1, 1'b1);
        repeat (4) tick(1'b0, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1);

        // Random valid, ready and data; fields change while frames are in flight.
        for (int i = 0; i < 300; i++) begin
            tick(1'($urandom), 4'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; (i < 8) && (q.size() > 0); i++) tick(1'b0, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1);

        // Counter wrap: 256 frames return to zero, one more gives one.
        doReset();
        runFrames(256);
        check("frames_wrap", io_frames_sent, 8'd0);
        runFrames(1);
        check("frames_after_wrap", io_frames_sent, 8'd1);

        // Beat-width sweep: reassemble each instance's beats and compare to P.
        for (int f = 0; f < 6; f++) begin
            @(negedge clock);
            io_in_aUInt4        = 4'($urandom);
            io_in_aSInt5        = 5'($urandom);
            io_in_aBundle_aBool = 1'($urandom);
            io_in_aBottomBool   = 1'($urandom);
            swValid             = 1'b1;
            #1;
            p = modelPack(io_in_aUInt4, io_in_aSInt5, io_in_aBundle_aBool, io_in_aBottomBool);
            for (int i = 0; i < 3; i++) begin
                check("sw_in_ready", swInReady[i], 1'b1);
                cnt[i] = 0;
                acc[i] = '0;
            end
            @(negedge clock);
            swValid = 1'b0;
            for (int c = 0; c < 12; c++) begin
                #1;
                for (int i = 0; i < 3; i++) begin
                    if (swOutValid[i]) begin
                        acc[i] = acc[i] | (64'(swBits[i]) << (cnt[i] * bw[i]));
                        check("sw_last", swLast[i], cnt[i] == nb[i] - 1);
                        cnt[i]++;
                    end
                end
                @(negedge clock);
            end
            for (int i = 0; i < 3; i++) begin
                check("sw_beats", cnt[i], nb[i]);
                check("sw_word",  acc[i], 64'(p));
            end
        end
        for (int i = 0; i < 3; i++) check("sw_frames", swFrames[i], 8'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
